// File: rtl/sprite_pkg.sv
// Shared types and raster constants for the sprite tile renderer.
package sprite_pkg;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        logic   flip;
    } origin_t;

    localparam int H_ACTIVE_C = 640;
    localparam int V_ACTIVE_C = 480;

endpackage

// File: rtl/sprite_axis_counter.sv
// One sprite axis: a 0..SCALE-1 sub-texel counter driving a texel base that steps by STRIDE.
// The base saturates at (LIMIT-1)*STRIDE.
module sprite_axis_counter
    import sprite_pkg::*;
#(
    parameter int SCALE  = 1,
    parameter int STRIDE = 1,
    parameter int LIMIT  = 1,
    parameter int ADDR_W = 12
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] base
);

    localparam int SX_W = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'((LIMIT - 1) * STRIDE);

    logic [SX_W-1:0]   sx_q;
    logic [SX_W-1:0]   sx_cur;
    logic [ADDR_W-1:0] base_q;

    // A clear takes effect for the current pixel, so the first window texel needs no extra cycle.
    always_comb begin
        sx_cur = clear ? '0 : sx_q;
        base   = clear ? '0 : base_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            sx_q   <= '0;
            base_q <= '0;
        end else if (advance) begin
            if (sx_cur == SX_W'(SCALE - 1)) begin
                sx_q   <= '0;
                base_q <= (base == LAST) ? base : base + ADDR_W'(STRIDE);
            end else begin
                sx_q   <= sx_cur + 1'b1;
                base_q <= base;
            end
        end else if (clear) begin
            sx_q   <= '0;
            base_q <= '0;
        end
    end

endmodule

// File: rtl/sprite_tile_renderer.sv
// Sprite pixel engine: places one integer-scaled sprite on the VGA raster and emits a latency-aligned
// palette index with an opaque-hit flag. Define SPRITE_MIRROR_EN to enable horizontal mirroring via flip_x.
module sprite_tile_renderer
    import sprite_pkg::*;
#(
    parameter int SPRITE_W   = 55,
    parameter int SPRITE_H   = 55,
    parameter int ADDR_W     = 12,
    parameter int IDX_W      = 2,
    parameter int SCALE      = 1,
    parameter int ROM_LAT    = 1,
    parameter int H_ACTIVE   = H_ACTIVE_C,
    parameter int V_ACTIVE   = V_ACTIVE_C,
    parameter int TRANSP_IDX = 0
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              pos_valid,
    output logic              pos_ready,
    input  logic              flip_x,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_index,
    output logic              pix_hit
);

    localparam int WIN_W = SPRITE_W * SCALE;
    localparam int WIN_H = SPRITE_H * SCALE;

    origin_t           pending;
    origin_t           origin;
    logic              pending_full;
    logic              shown;
    logic              commit;
    logic              accept;
    logic              flip_req;
    logic [10:0]       px;
    logic [10:0]       py;
    logic [10:0]       x_lo;
    logic [10:0]       y_lo;
    logic              in_x;
    logic              in_y;
    logic              win;
    logic              col_clear;
    logic              row_adv;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] tex_col;
    logic [ROM_LAT:0]  win_d;
    logic              hit_next;

    assign commit    = (DrawX == 10'd0) && (DrawY == 10'(V_ACTIVE));
    assign accept    = pos_valid && !pending_full;
    assign pos_ready = !pending_full;

`ifdef SPRITE_MIRROR_EN
    assign flip_req = flip_x;
    assign tex_col  = origin.flip ? ADDR_W'(SPRITE_W - 1) - col : col;
`else
    logic unused_flip;
    assign flip_req    = 1'b0;
    assign tex_col     = col;
    assign unused_flip = flip_x ^ origin.flip;
`endif

    // A single pending slot: new origins only reach the live origin at the frame boundary.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            origin       <= '0;
            pending_full <= 1'b0;
            shown        <= 1'b0;
        end else begin
            if (commit && pending_full) begin
                origin <= pending;
                shown  <= 1'b1;
            end
            if (accept) begin
                pending      <= '{x: pos_x, y: pos_y, flip: flip_req};
                pending_full <= 1'b1;
            end else if (commit) begin
                pending_full <= 1'b0;
            end
        end
    end

    // 11-bit bounds keep sprites near the right/bottom edge from wrapping to column/row 0.
    always_comb begin
        px        = {1'b0, DrawX};
        py        = {1'b0, DrawY};
        x_lo      = {1'b0, origin.x};
        y_lo      = {1'b0, origin.y};
        in_x      = (px >= x_lo) && (px < x_lo + 11'(WIN_W));
        in_y      = (py >= y_lo) && (py < y_lo + 11'(WIN_H));
        win       = shown && blank && in_x && in_y;
        col_clear = (DrawX == origin.x);
        row_adv   = shown && in_y && (DrawX == 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
    end

    sprite_axis_counter #(
        .SCALE  (SCALE),
        .STRIDE (1),
        .LIMIT  (SPRITE_W),
        .ADDR_W (ADDR_W)
    ) u_x_axis (
        .vga_clk (vga_clk),
        .reset   (reset),
        .clear   (col_clear),
        .advance (win),
        .base    (col)
    );

    sprite_axis_counter #(
        .SCALE  (SCALE),
        .STRIDE (SPRITE_W),
        .LIMIT  (SPRITE_H),
        .ADDR_W (ADDR_W)
    ) u_y_axis (
        .vga_clk (vga_clk),
        .reset   (reset),
        .clear   (commit),
        .advance (row_adv),
        .base    (row_base)
    );

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rom_address <= '0;
        end else if (win) begin
            rom_address <= row_base + tex_col;
        end
    end

    // The window flag travels ROM_LAT+1 stages so it meets the ROM data of the same pixel.
    assign hit_next = win_d[ROM_LAT] && (rom_q != IDX_W'(TRANSP_IDX));

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            win_d     <= '0;
            pix_hit   <= 1'b0;
            pix_index <= '0;
        end else begin
            win_d     <= {win_d[ROM_LAT-1:0], win};
            pix_hit   <= hit_next;
            pix_index <= hit_next ? rom_q : '0;
        end
    end

endmodule

// File: tb/tb_sprite_tile_renderer.sv
// Directed bench for sprite_tile_renderer: one SCALE=1 and one SCALE=2 instance share the raster inputs.
module tb_sprite_tile_renderer;

    localparam int ADDR_W = 12;
    localparam int IDX_W  = 2;
    localparam int PIPE   = 2;
`ifdef SPRITE_MIRROR_EN
    localparam int MIR_FIRST = 54;
`else
    localparam int MIR_FIRST = 0;
`endif

    logic              vga_clk = 1'b0;
    logic              reset;
    logic [9:0]        DrawX, DrawY, pos_x, pos_y;
    logic              blank, pos_valid, flip_x;
    logic              pos_ready, pos_ready2;
    logic [ADDR_W-1:0] rom_address, rom_address2;
    logic [IDX_W-1:0]  rom_q, rom_q2, pix_index, pix_index2;
    logic              pix_hit, pix_hit2;

    logic [ADDR_W-1:0] addr_log  [0:1023];
    logic              hit_log   [0:1023];
    logic [IDX_W-1:0]  idx_log   [0:1023];
    logic [ADDR_W-1:0] addr2_log [0:1023];
    logic              hit2_log  [0:1023];
    logic [IDX_W-1:0]  idx2_log  [0:1023];
    int                xq[$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 vga_clk = ~vga_clk;

    sprite_tile_renderer #(.SCALE(1), .ROM_LAT(1)) dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .pos_ready(pos_ready),
        .flip_x(flip_x), .rom_address(rom_address), .rom_q(rom_q),
        .pix_index(pix_index), .pix_hit(pix_hit)
    );

    sprite_tile_renderer #(.SCALE(2), .ROM_LAT(1)) dut2 (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .pos_ready(pos_ready2),
        .flip_x(flip_x), .rom_address(rom_address2), .rom_q(rom_q2),
        .pix_index(pix_index2), .pix_hit(pix_hit2)
    );

    // Sprite ROM: address 5 is transparent, everything else is (addr % 3) + 1.
    function automatic logic [IDX_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
        if (a == 12'd5) return '0;
        return IDX_W'((a % 3) + 1);
    endfunction

    always_ff @(posedge vga_clk) begin
        rom_q  <= rom_f(rom_address);
        rom_q2 <= rom_f(rom_address2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one raster position, then log the address for it and the pixel output PIPE samples back.
    task automatic tick(input int x, input int y, input logic vis);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = vis;
        @(posedge vga_clk);
        #1;
        addr_log[x]  = rom_address;
        addr2_log[x] = rom_address2;
        xq.push_back(x);
        if (xq.size() > PIPE) begin
            int xo = xq.pop_front();
            hit_log[xo]  = pix_hit;
            idx_log[xo]  = pix_index;
            hit2_log[xo] = pix_hit2;
            idx2_log[xo] = pix_index2;
        end
    endtask

    task automatic line(input int y, input int x_lo, input int x_hi);
        xq.delete();
        for (int x = x_lo; x <= x_hi; x++) tick(x, y, (x < 640) && (y < 480));
        for (int x = 640; x <= 642; x++) tick(x, y, 1'b0);
    endtask

    task automatic request(input int x, input int y, input logic f);
        pos_x     = 10'(x);
        pos_y     = 10'(y);
        flip_x    = f;
        pos_valid = 1'b1;
        tick(700, 500, 1'b0);
        pos_valid = 1'b0;
        flip_x    = 1'b0;
    endtask

    task automatic commit_tick();
        tick(0, 480, 1'b0);
    endtask

    initial begin
        reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0;
        pos_x = '0; pos_y = '0; pos_valid = 1'b0; flip_x = 1'b0;
        repeat (2) @(posedge vga_clk);
        #1;
        check("reset_addr", 32'(rom_address), 0);
        check("reset_hit", 32'(pix_hit), 0);
        check("reset_idx", 32'(pix_index), 0);
        check("reset_ready", 32'(pos_ready), 1);
        reset = 1'b0;

        line(0, 0, 5);
        check("hidden_before_commit", 32'(hit_log[2]), 0);

        request(100, 50, 1'b0);
        check("ready_drops", 32'(pos_ready), 0);
        request(200, 60, 1'b0);
        check("ready_held", 32'(pos_ready), 0);
        commit_tick();
        check("ready_after_commit", 32'(pos_ready), 1);

        line(50, 96, 160);
        check("s1_first_addr", 32'(addr_log[100]), 0);
        check("s1_hit_before", 32'(hit_log[99]), 0);
        check("s1_hit_first", 32'(hit_log[100]), 1);
        check("s1_idx_first", 32'(idx_log[100]), 1);
        check("s1_hit_104", 32'(hit_log[104]), 1);
        check("transp_hit", 32'(hit_log[105]), 0);
        check("transp_idx", 32'(idx_log[105]), 0);
        check("s1_hit_106", 32'(hit_log[106]), 1);
        check("s1_hit_last", 32'(hit_log[154]), 1);
        check("s1_hit_end", 32'(hit_log[155]), 0);
        check("s1_addr_hold", 32'(addr_log[156]), 54);
        line(51, 96, 160);
        check("s1_row1_addr", 32'(addr_log[154]), 109);
        check("s1_row1_hit", 32'(hit_log[154]), 1);

        request(0, 0, 1'b0);
        check("ready_drops_2", 32'(pos_ready), 0);
        line(52, 0, 102);
        check("old_origin_x0", 32'(hit_log[0]), 0);
        check("old_origin_hit", 32'(hit_log[100]), 1);
        check("old_origin_addr", 32'(addr_log[100]), 110);
        commit_tick();

        line(0, 0, 115);
        check("s2_addr_x1", 32'(addr2_log[1]), 0);
        check("s2_addr_x2", 32'(addr2_log[2]), 1);
        line(1, 0, 115);
        check("s2_row_repeat", 32'(addr2_log[2]), 1);
        line(2, 0, 115);
        check("s2_addr_2_2", 32'(addr2_log[2]), 56);
        check("s2_idx_2_2", 32'(idx2_log[2]), 3);
        check("s2_addr_109", 32'(addr2_log[109]), 109);
        check("s2_hit_109", 32'(hit2_log[109]), 1);
        check("s2_hit_110", 32'(hit2_log[110]), 0);

        request(620, 470, 1'b0);
        commit_tick();
        line(469, 615, 639);
        check("clip_row_above", 32'(hit_log[620]), 0);
        line(470, 0, 639);
        check("clip_hit_619", 32'(hit_log[619]), 0);
        check("clip_hit_620", 32'(hit_log[620]), 1);
        check("clip_idx_620", 32'(idx_log[620]), 1);
        check("clip_hit_639", 32'(hit_log[639]), 1);
        check("clip_addr_639", 32'(addr_log[639]), 19);
        line(471, 0, 639);
        check("clip_no_wrap_x0", 32'(hit_log[0]), 0);
        for (int y = 472; y < 479; y++) line(y, 0, 639);
        line(479, 0, 639);
        check("clip_last_row_addr", 32'(addr_log[620]), 495);
        check("clip_last_row_hit", 32'(hit_log[620]), 1);

        request(100, 50, 1'b1);
        commit_tick();
        line(50, 96, 110);
        check("mirror_first_addr", 32'(addr_log[100]), MIR_FIRST);

        request(300, 300, 1'b0);
        check("ready_before_reset", 32'(pos_ready), 0);
        tick(100, 51, 1'b1);
        tick(101, 51, 1'b1);
        tick(102, 51, 1'b1);
        check("pre_reset_hit", 32'(pix_hit), 1);
        reset = 1'b1;
        #1;
        check("async_reset_addr", 32'(rom_address), 0);
        check("async_reset_hit", 32'(pix_hit), 0);
        check("async_reset_idx", 32'(pix_index), 0);
        check("async_reset_ready", 32'(pos_ready), 1);
        @(posedge vga_clk);
        #1;
        check("reset_edge_hit", 32'(pix_hit), 0);
        reset = 1'b0;
        line(0, 0, 5);
        check("hidden_after_reset", 32'(hit_log[2]), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
